// File: rtl/bus_mem_slave_if.sv
// Shared system bus between one master and the memory responder.
//   addr_bus      : byte address from the master
//   data_bus      : bidirectional data; master drives write data, slave drives read data
//   wr_bus/rd_bus : write/read request, held by the master until fc_bus is seen high
//   data_mask_bus : byte enables for writes, bit i covers data_bus[8i+7:8i]
//   fc_bus        : function complete, driven by the selected slave only
interface bus_mem_slave_if;
  logic [31:0] addr_bus;
  wire  [31:0] data_bus;
  logic        wr_bus;
  logic        rd_bus;
  logic [3:0]  data_mask_bus;
  wire         fc_bus;

  modport master (
    output addr_bus, wr_bus, rd_bus, data_mask_bus,
    inout  data_bus, fc_bus
  );

  modport slave (
    input  addr_bus, wr_bus, rd_bus, data_mask_bus,
    inout  data_bus, fc_bus
  );
endinterface

// File: rtl/bus_mem_slave.sv
// Word-organised RAM responder on the shared system bus.
// Decodes its address window, counts WAIT_STATES wait cycles, then completes the
// access by driving fc_bus high (and data_bus with the read word on reads).
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset (memory contents are kept)
//   bus : slave modport of bus_mem_slave_if (addr/data/wr/rd/mask/fc)
module bus_mem_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned SIZE_WORDS  = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input logic            clk,
  input logic            rst,
  bus_mem_slave_if.slave bus
);

  localparam int unsigned AW      = $clog2(SIZE_WORDS);
  localparam int unsigned TAG_LSB = AW + 2;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          op_wr_q, op_wr_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   mem_q [SIZE_WORDS];

  logic          hit_c;
  logic          req_c;
  logic          mem_we_c;
  logic          fc_oe_c;
  logic          data_oe_c;
  logic [AW-1:0] index_c;

  // Window is aligned to its size, so decode is a tag compare on the upper bits.
  assign hit_c   = (bus.addr_bus[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
  assign index_c = bus.addr_bus[TAG_LSB-1:2];
  // rd and wr together is a protocol error and is ignored as no request.
  assign req_c   = hit_c && (bus.rd_bus ^ bus.wr_bus);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      op_wr_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic. Acceptance always passes through WAIT, so the counter is loaded
  // with the full wait-state count and fc rises WAIT_STATES+1 edges after acceptance.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_wr_d  = op_wr_q;
    rdata_d  = rdata_q;
    mem_we_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_c) begin
          op_wr_d = bus.wr_bus;
          cnt_d   = WAIT_INIT;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!req_c || (bus.wr_bus != op_wr_q)) begin
          // Master abandoned or changed the request: abort without touching memory.
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
          if (op_wr_q) begin
            mem_we_c = 1'b1;
          end else begin
            rdata_d = mem_q[index_c];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        if (!bus.rd_bus && !bus.wr_bus) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Byte-masked write on the edge entering DONE; storage has no reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.data_mask_bus[b]) begin
          mem_q[index_c][8*b +: 8] <= bus.data_bus[8*b +: 8];
        end
      end
    end
  end

  // Bus drivers: only while this slave owns the transfer.
  assign fc_oe_c      = (state_q != ST_IDLE);
  assign data_oe_c    = (state_q == ST_DONE) && !op_wr_q;
  assign bus.fc_bus   = fc_oe_c   ? (state_q == ST_DONE) : 1'bz;
  assign bus.data_bus = data_oe_c ? rdata_q : 32'bz;

endmodule
